systolic_output_collector: RTL and testbench



---
 rtl/systolic_output_collector.sv | 189 ++++++++++++++++++
 tb/tb_systolic_output_collector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_collector.sv
// Systolic output collector: de-skews NUM_COL time-staggered column results
// into one aligned row, tags tile boundaries and buffers rows in a
// show-ahead FIFO drained over a valid/ready stream.
module systolic_output_collector #(
    parameter int NUM_COL    = 4,
    parameter int BW_ACCU    = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BW_ROWCNT  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic [NUM_COL*BW_ACCU-1:0]    col_data_in,
    input  logic                          valid_in,
    input  logic [BW_ROWCNT-1:0]          row_count_cfg,
    output logic [NUM_COL*BW_ACCU-1:0]    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow_err,
    output logic                          busy
);

    localparam int DW = NUM_COL * BW_ACCU;
    localparam int ND = NUM_COL - 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] aligned_row_s;
    logic          aligned_valid_s;
    logic          dly_busy_s;

    // Last column needs no delay and passes straight through.
    assign aligned_row_s[NUM_COL*BW_ACCU-1 -: BW_ACCU] = col_data_in[NUM_COL*BW_ACCU-1 -: BW_ACCU];

    generate
        if (ND > 0) begin : g_skew
            logic [ND-1:0] vld_r;

            // Valid shift register; its tail marks the cycle the row is aligned.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_r <= '0;
                end else if (clear) begin
                    vld_r <= '0;
                end else begin
                    vld_r[0] <= valid_in;
                    for (int s = 1; s < ND; s++) begin
                        vld_r[s] <= vld_r[s-1];
                    end
                end
            end

            assign aligned_valid_s = vld_r[ND-1];
            assign dly_busy_s      = |vld_r;

            for (genvar c = 0; c < ND; c++) begin : g_col
                localparam int D = ND - c;
                logic [BW_ACCU-1:0] pipe_r [D];

                // Column c is delayed by NUM_COL-1-c stages to line up with the last column.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        for (int s = 0; s < D; s++) begin
                            pipe_r[s] <= '0;
                        end
                    end else if (clear) begin
                        for (int s = 0; s < D; s++) begin
                            pipe_r[s] <= '0;
                        end
                    end else begin
                        pipe_r[0] <= col_data_in[c*BW_ACCU +: BW_ACCU];
                        for (int s = 1; s < D; s++) begin
                            pipe_r[s] <= pipe_r[s-1];
                        end
                    end
                end

                assign aligned_row_s[c*BW_ACCU +: BW_ACCU] = pipe_r[D-1];
            end
        end else begin : g_noskew
            assign aligned_valid_s = valid_in;
            assign dly_busy_s      = 1'b0;
        end
    endgenerate

    logic [DW:0]           mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [LW-1:0]         count_r;
    logic [BW_ROWCNT-1:0]  row_cnt_r;
    logic                  ovf_r;

    logic [BW_ROWCNT-1:0]  cfg_last_s;
    logic                  row_last_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;

    // Handshake decode and tile-boundary detection (cfg of 0 behaves as 1).
    always_comb begin
        cfg_last_s = '0;
        if (row_count_cfg != {BW_ROWCNT{1'b0}}) begin
            cfg_last_s = row_count_cfg - BW_ROWCNT'(1);
        end else begin
            cfg_last_s = '0;
        end
        row_last_s = (row_cnt_r >= cfg_last_s);
        full_s     = (count_r == LW'(FIFO_DEPTH));
        pop_s      = (count_r != {LW{1'b0}}) && out_ready;
        push_s     = aligned_valid_s && (!full_s || pop_s);
        drop_s     = aligned_valid_s && full_s && !pop_s;
    end

    // FIFO storage: {last, row} written on push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= {row_last_s, aligned_row_s};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Row counter advances on every aligned row, stored or dropped, so framing survives drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_cnt_r <= '0;
        end else if (clear) begin
            row_cnt_r <= '0;
        end else if (aligned_valid_s) begin
            row_cnt_r <= row_last_s ? {BW_ROWCNT{1'b0}} : row_cnt_r + BW_ROWCNT'(1);
        end else begin
            row_cnt_r <= row_cnt_r;
        end
    end

    // Output view: everything below is derived straight from registers.
    always_comb begin
        out_data     = mem_r[rd_ptr_r][DW-1:0];
        out_last     = mem_r[rd_ptr_r][DW];
        out_valid    = (count_r != {LW{1'b0}});
        fifo_level   = count_r;
        overflow_err = ovf_r;
        busy         = dly_busy_s || (count_r != {LW{1'b0}});
    end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Randomized scoreboard bench for systolic_output_collector.
module tb_systolic_output_collector;

    localparam int NC    = 4;
    localparam int BW    = 32;
    localparam int DEPTH = 4;
    localparam int RCW   = 16;
    localparam int DW    = NC * BW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clear;
    logic [DW-1:0]     col_data_in;
    logic              valid_in;
    logic [RCW-1:0]    row_count_cfg;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [2:0]        fifo_level;
    logic              overflow_err;
    logic              busy;

    systolic_output_collector #(
        .NUM_COL(NC), .BW_ACCU(BW), .FIFO_DEPTH(DEPTH), .BW_ROWCNT(RCW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .col_data_in(col_data_in), .valid_in(valid_in),
        .row_count_cfg(row_count_cfg), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .fifo_level(fifo_level), .overflow_err(overflow_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int issue; int due; } pend_t;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    logic [DW-1:0] rows [int];      // intended row for each issue cycle
    pend_t         pend [$];        // rows travelling through the skew
    logic [DW:0]   q [$];           // model FIFO: {last, row}
    int            rc    = 0;       // model row-in-tile index
    bit            m_ovf = 1'b0;

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int c = 0; c < NC; c++) r[c*BW +: BW] = $urandom;
        return r;
    endfunction

    // Drive one cycle of inputs; column c carries the row issued c cycles ago.
    task automatic step(input bit v, input bit rdy, input bit clr);
        logic [DW-1:0] d;
        valid_in  = v;
        out_ready = rdy;
        clear     = clr;
        if (v) rows[cyc] = rand_row();
        for (int c = 0; c < NC; c++) begin
            if (rows.exists(cyc - c)) d[c*BW +: BW] = rows[cyc - c][c*BW +: BW];
            else                      d[c*BW +: BW] = $urandom;
        end
        col_data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: advances once per clock edge from the inputs of the ending cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n || clear) begin
                q.delete();
                pend.delete();
                rc    = 0;
                m_ovf = 1'b0;
            end else begin
                bit pop;
                pop = (q.size() != 0) && out_ready;
                if (valid_in) pend.push_back('{issue: cyc, due: cyc + NC - 1});
                if (pend.size() != 0 && pend[0].due == cyc) begin
                    int  eff;
                    bit  last;
                    eff  = (row_count_cfg == 0) ? 1 : int'(row_count_cfg);
                    last = (rc >= eff - 1);
                    rc   = last ? 0 : rc + 1;
                    if (q.size() == DEPTH && !pop) m_ovf = 1'b1;
                    else q.push_back({last, rows[pend[0].issue]});
                    void'(pend.pop_front());
                end
                if (pop) void'(q.pop_front());
            end
            cyc++;
        end
    end

    // Monitor: compares the DUT's presented state with the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_valid", {128'd0, out_valid}, '0);
                chk("rst_level", {126'd0, fifo_level}, '0);
                chk("rst_ovf",   {128'd0, overflow_err}, '0);
                chk("rst_busy",  {128'd0, busy}, '0);
                chk("rst_data",  {out_last, out_data}, '0);
            end else begin
                chk("out_valid", {128'd0, out_valid}, {128'd0, (q.size() != 0)});
                chk("fifo_level", {126'd0, fifo_level}, (DW+1)'(q.size()));
                chk("overflow_err", {128'd0, overflow_err}, {128'd0, m_ovf});
                chk("busy", {128'd0, busy}, {128'd0, (q.size() != 0 || pend.size() != 0)});
                if (out_valid && q.size() != 0) chk("row", {out_last, out_data}, q[0]);
            end
        end
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; valid_in = 1'b0; out_ready = 1'b1;
        row_count_cfg = 16'd1; col_data_in = '0;
        repeat (2) step(1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);

        // single row, every row a tile
        step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);

        // six back-to-back rows
        repeat (6) step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);

        // backpressure: five rows into a four-deep FIFO, then drain
        repeat (5) step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);

        // full FIFO with push and pop together
        repeat (4) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);

        // last tagging with 3-row tiles, then cfg 0
        step(1'b0, 1'b1, 1'b1);
        row_count_cfg = 16'd3;
        repeat (7) step(1'b1, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        row_count_cfg = 16'd0;
        repeat (5) step(1'b1, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);

        // clear with rows both in the FIFO and in the skew lines
        row_count_cfg = 16'd2;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b1, 1'b0);

        // same scenario with an asynchronous reset pulse
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (10) step(1'b0, 1'b1, 1'b0);

        // random traffic with config changes and occasional clears
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) row_count_cfg = 16'($urandom_range(0, 4));
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 199) == 0));
        end
        repeat (10) step(1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
